// File: rtl/pkt_comp_sched_pkg.sv
// pkt_comp_sched_pkg: shared types for the pkt_Comp ingress scheduler.
//   pkHeadInfo      - packet header carried alongside the payload into the sorter
//   sched_state_e   - ingress FSM states
//   PKT_SCHED_CNT_W - width of the per-requester grant statistics counters
package pkt_comp_sched_pkg;

  localparam int unsigned PKT_SCHED_CNT_W = 16;

  typedef struct packed {
    logic [5:0]  prior;
    logic [9:0]  len;
    logic [15:0] flow_id;
  } pkHeadInfo;

  typedef enum logic [0:0] {
    SCHED_IDLE,
    SCHED_HOLD
  } sched_state_e;

endpackage

// File: rtl/pkt_comp_sched_rr_arb.sv
// pkt_rr_arb: combinational round-robin arbiter.
//   req     - request vector
//   ptr     - index where the search starts (register lives in the parent)
//   gnt     - one-hot grant, all zero when no request
//   gnt_idx - index of the granted requester (0 when no request)
module pkt_rr_arb #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned PTR_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PTR_W-1:0]   gnt_idx
);

  logic found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      int unsigned        idx;
      logic [PTR_W-1:0]   idx_t;
      idx   = (int'(ptr) + off) % NUM_REQ;
      idx_t = PTR_W'(idx);
      if (!found && req[idx_t]) begin
        found      = 1'b1;
        gnt[idx_t] = 1'b1;
        gnt_idx    = idx_t;
      end
    end
  end

endmodule

// File: rtl/pkt_comp_sched.sv
// pkt_comp_sched: ingress scheduler and dequeue sequencer for the pkt_Comp sorter.
//   req_*            - NUM_REQ requesters, one-hot req_ready grant in IDLE
//   cmp_in_*         - insert port toward the sorter, driven from the hold register
//   cmp_out_*        - sorter head (show-ahead) and pop strobe
//   deq_*            - consumer side: level request, one-cycle result pulse
//   occ              - packets currently held by the sorter
//   stat_grant_cnt   - per-requester saturating grant counters
// Build option: define PKT_COMP_SCHED_STATS_EN to build the grant counters;
// otherwise stat_grant_cnt is tied to zero.
module pkt_comp_sched
  import pkt_comp_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DWIDTH    = 32,
  parameter int unsigned SLOT_SIZE = 8,
  localparam int unsigned OCC_W    = $clog2(SLOT_SIZE + 1),
  localparam int unsigned PTR_W    = $clog2(NUM_REQ)
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [NUM_REQ-1:0]                      req_valid,
  output logic [NUM_REQ-1:0]                      req_ready,
  input  pkHeadInfo [NUM_REQ-1:0]                 req_info,
  input  logic [NUM_REQ-1:0][DWIDTH-1:0]          req_data,
  output logic                                    cmp_in_en,
  input  logic                                    cmp_in_valid,
  output pkHeadInfo                               cmp_in_pkt_info,
  output logic [DWIDTH-1:0]                       cmp_in_data,
  output logic                                    cmp_out_deque_en,
  input  logic                                    cmp_out_valid,
  input  logic [DWIDTH-1:0]                       cmp_out_data,
  input  logic [5:0]                              cmp_out_prior,
  input  logic                                    deq_req,
  output logic                                    deq_valid,
  output logic [DWIDTH-1:0]                       deq_data,
  output logic [5:0]                              deq_prior,
  output logic [OCC_W-1:0]                        occ,
  output logic [NUM_REQ-1:0][PKT_SCHED_CNT_W-1:0] stat_grant_cnt
);

  sched_state_e      state_q;
  logic [PTR_W-1:0]  ptr_q;
  logic [OCC_W-1:0]  occ_q;
  pkHeadInfo         hold_info_q;
  logic [DWIDTH-1:0] hold_data_q;
  logic              deq_valid_q;
  logic [DWIDTH-1:0] deq_data_q;
  logic [5:0]        deq_prior_q;

  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] arb_gnt;
  logic [PTR_W-1:0]   arb_idx;

  // Arbitration is only offered while idle, so the grant doubles as req_ready.
  assign arb_req = (state_q == SCHED_IDLE) ? req_valid : '0;

  pkt_rr_arb #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req     (arb_req),
    .ptr     (ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  assign req_ready        = arb_gnt;
  // occ is compared before this edge's pop, so a full sorter blocks for one extra cycle.
  assign cmp_in_en        = (state_q == SCHED_HOLD) && cmp_in_valid &&
                            (occ_q < OCC_W'(SLOT_SIZE));
  // occ gate guards against a spurious head-valid while the sorter is empty.
  assign cmp_out_deque_en = deq_req && cmp_out_valid && (occ_q != '0) && !deq_valid_q;

  assign cmp_in_pkt_info  = hold_info_q;
  assign cmp_in_data      = hold_data_q;
  assign deq_valid        = deq_valid_q;
  assign deq_data         = deq_data_q;
  assign deq_prior        = deq_prior_q;
  assign occ              = occ_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SCHED_IDLE;
      ptr_q       <= '0;
      hold_info_q <= '0;
      hold_data_q <= '0;
    end else begin
      unique case (state_q)
        SCHED_IDLE: begin
          if (|arb_gnt) begin
            hold_info_q <= req_info[arb_idx];
            hold_data_q <= req_data[arb_idx];
            ptr_q       <= (arb_idx == PTR_W'(NUM_REQ - 1)) ? '0 : arb_idx + PTR_W'(1);
            state_q     <= SCHED_HOLD;
          end
        end
        SCHED_HOLD: begin
          if (cmp_in_en) state_q <= SCHED_IDLE;
        end
        default: state_q <= SCHED_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= '0;
    end else begin
      unique case ({cmp_in_en, cmp_out_deque_en})
        2'b10:   occ_q <= occ_q + OCC_W'(1);
        2'b01:   occ_q <= occ_q - OCC_W'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deq_valid_q <= 1'b0;
      deq_data_q  <= '0;
      deq_prior_q <= '0;
    end else begin
      deq_valid_q <= cmp_out_deque_en;
      if (cmp_out_deque_en) begin
        deq_data_q  <= cmp_out_data;
        deq_prior_q <= cmp_out_prior;
      end
    end
  end

`ifdef PKT_COMP_SCHED_STATS_EN
  logic [NUM_REQ-1:0][PKT_SCHED_CNT_W-1:0] stat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (arb_gnt[i] && (stat_q[i] != '1)) stat_q[i] <= stat_q[i] + PKT_SCHED_CNT_W'(1);
      end
    end
  end

  assign stat_grant_cnt = stat_q;
`else
  assign stat_grant_cnt = '0;
`endif

endmodule

// File: tb/tb_pkt_comp_sched.sv
// tb_pkt_comp_sched: directed bench with a scoreboard for grants, inserts and dequeues.
module tb_pkt_comp_sched;
  import pkt_comp_sched_pkg::*;

  logic                  clk;
  logic                  rst_n;
  logic [3:0]            req_valid;
  logic [3:0]            req_ready;
  pkHeadInfo [3:0]       req_info;
  logic [3:0][31:0]      req_data;
  logic                  cmp_in_en;
  logic                  cmp_in_valid;
  pkHeadInfo             cmp_in_pkt_info;
  logic [31:0]           cmp_in_data;
  logic                  cmp_out_deque_en;
  logic                  cmp_out_valid;
  logic [31:0]           cmp_out_data;
  logic [5:0]            cmp_out_prior;
  logic                  deq_req;
  logic                  deq_valid;
  logic [31:0]           deq_data;
  logic [5:0]            deq_prior;
  logic [3:0]            occ;
  logic [3:0][15:0]      stat_grant_cnt;

  pkt_comp_sched #(
    .NUM_REQ   (4),
    .DWIDTH    (32),
    .SLOT_SIZE (8)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_info         (req_info),
    .req_data         (req_data),
    .cmp_in_en        (cmp_in_en),
    .cmp_in_valid     (cmp_in_valid),
    .cmp_in_pkt_info  (cmp_in_pkt_info),
    .cmp_in_data      (cmp_in_data),
    .cmp_out_deque_en (cmp_out_deque_en),
    .cmp_out_valid    (cmp_out_valid),
    .cmp_out_data     (cmp_out_data),
    .cmp_out_prior    (cmp_out_prior),
    .deq_req          (deq_req),
    .deq_valid        (deq_valid),
    .deq_data         (deq_data),
    .deq_prior        (deq_prior),
    .occ              (occ),
    .stat_grant_cnt   (stat_grant_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    pkHeadInfo   info;
    logic [31:0] data;
  } ins_t;

  typedef struct packed {
    logic [31:0] data;
    logic [5:0]  prior;
  } deq_t;

  ins_t       ins_q[$];
  deq_t       deq_q[$];
  logic [3:0] gnt_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic ins_t mk_ins(input int i);
    mk_ins.info = req_info[i];
    mk_ins.data = req_data[i];
  endfunction

  // Monitor: compares every DUT transaction against the head of its queue.
  logic [3:0] mon_g;
  ins_t       mon_i;
  deq_t       mon_d;
  always @(negedge clk) begin
    if (rst_n) begin
      check("ready_without_valid", 64'(req_ready & ~req_valid), 64'd0);
      if (|(req_ready & req_valid)) begin
        if (gnt_q.size() == 0) check("grant_unexpected", 64'(req_ready), 64'd0);
        else begin
          mon_g = gnt_q.pop_front();
          check("grant", 64'(req_ready), 64'(mon_g));
        end
      end
      if (cmp_in_en) begin
        if (ins_q.size() == 0) check("insert_unexpected", 64'(cmp_in_en), 64'd0);
        else begin
          mon_i = ins_q.pop_front();
          check("insert_pkt", {cmp_in_pkt_info, cmp_in_data}, 64'(mon_i));
        end
      end
      if (deq_valid) begin
        if (deq_q.size() == 0) check("deq_unexpected", 64'(deq_valid), 64'd0);
        else begin
          mon_d = deq_q.pop_front();
          check("deq_result", 64'({deq_data, deq_prior}), 64'(mon_d));
        end
      end
    end
  end

  initial begin
    rst_n         = 1'b0;
    req_valid     = '0;
    cmp_in_valid  = 1'b0;
    cmp_out_valid = 1'b0;
    cmp_out_data  = '0;
    cmp_out_prior = '0;
    deq_req       = 1'b0;
    req_info[0]   = '{prior: 6'd1, len: 10'd64,  flow_id: 16'hF000};
    req_info[1]   = '{prior: 6'd2, len: 10'd128, flow_id: 16'hF001};
    req_info[2]   = '{prior: 6'd3, len: 10'd192, flow_id: 16'hF002};
    req_info[3]   = '{prior: 6'd4, len: 10'd256, flow_id: 16'hF003};
    req_data[0]   = 32'h1111_0000;
    req_data[1]   = 32'h2222_0001;
    req_data[2]   = 32'h3333_0002;
    req_data[3]   = 32'h4444_0003;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_occ", 64'(occ), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_cmp_in_en", 64'(cmp_in_en), 64'd0);
    check("rst_deque_en", 64'(cmp_out_deque_en), 64'd0);
    check("rst_deq", 64'({deq_valid, deq_data, deq_prior}), 64'd0);
    check("rst_hold", {cmp_in_pkt_info, cmp_in_data}, 64'd0);
    check("rst_stats", 64'(stat_grant_cnt), 64'd0);
    rst_n = 1'b1;

    // All requesters busy: grants 0,1,2,3,0 every other cycle until the sorter fills
    cmp_in_valid = 1'b1;
    req_valid    = 4'hF;
    for (int k = 0; k < 9; k++) gnt_q.push_back(4'(1 << (k % 4)));
    for (int k = 0; k < 8; k++) ins_q.push_back(mk_ins(k % 4));
    for (int k = 0; k < 10; k++) begin
      #1;
      check("grant_cadence", 64'(req_ready), (k % 2 == 0) ? 64'(1 << ((k / 2) % 4)) : 64'd0);
      step();
    end
    repeat (12) step();
    check("full_occ", 64'(occ), 64'd8);
    check("full_no_insert", 64'(cmp_in_en), 64'd0);
    check("full_no_ready", 64'(req_ready), 64'd0);

    // Full + pop: pop this edge, insert only on the next one
    deq_req       = 1'b1;
    cmp_out_valid = 1'b1;
    cmp_out_data  = 32'hDEAD_0001;
    cmp_out_prior = 6'd5;
    deq_q.push_back('{data: 32'hDEAD_0001, prior: 6'd5});
    ins_q.push_back(mk_ins(0));
    gnt_q.push_back(4'b0010);
    #1;
    check("full_pop_en", 64'(cmp_out_deque_en), 64'd1);
    check("full_pop_blocks_insert", 64'(cmp_in_en), 64'd0);
    step();
    deq_req = 1'b0;
    #1;
    check("after_pop_occ", 64'(occ), 64'd7);
    check("after_pop_insert", 64'(cmp_in_en), 64'd1);
    check("after_pop_deq", 64'({deq_valid, deq_prior}), 64'({1'b1, 6'd5}));
    step();
    check("refill_occ", 64'(occ), 64'd8);
    step();

    // Drain to 3 with inserts held off; pops spaced every other cycle
    cmp_in_valid  = 1'b0;
    deq_req       = 1'b1;
    cmp_out_data  = 32'hBEEF_0002;
    cmp_out_prior = 6'd9;
    for (int k = 0; k < 5; k++) deq_q.push_back('{data: 32'hBEEF_0002, prior: 6'd9});
    repeat (10) step();
    deq_req = 1'b0;
    check("drain_occ", 64'(occ), 64'd3);

    // Insert and pop on the same edge: occ unchanged
    cmp_in_valid = 1'b1;
    deq_req      = 1'b1;
    deq_q.push_back('{data: 32'hBEEF_0002, prior: 6'd9});
    ins_q.push_back(mk_ins(1));
    gnt_q.push_back(4'b0100);
    #1;
    check("both_strobes", 64'({cmp_in_en, cmp_out_deque_en}), 64'd3);
    step();
    deq_req      = 1'b0;
    cmp_in_valid = 1'b0;
    check("same_edge_occ", 64'(occ), 64'd3);
    step();

    // Lone requester 2 after a grant to 2: granted again, pointer moves to 3
    req_valid    = 4'b0100;
    cmp_in_valid = 1'b1;
    ins_q.push_back(mk_ins(2));
    gnt_q.push_back(4'b0100);
    step();
    check("lone_grant", 64'(req_ready), 64'b0100);
    step();
    req_valid = 4'hF;
    ins_q.push_back(mk_ins(2));
    gnt_q.push_back(4'b1000);
    step();
    check("ptr_after_lone", 64'(req_ready), 64'b1000);
    cmp_in_valid = 1'b0;
    step();

    // Requester drops valid while held: captured packet stays put
    req_valid = '0;
    #1;
    check("hold_data", 64'(cmp_in_data), 64'(32'h4444_0003));
    check("hold_info", 64'(cmp_in_pkt_info), 64'(req_info[3]));
    repeat (2) step();
    check("hold_stable", {cmp_in_pkt_info, cmp_in_data}, 64'(mk_ins(3)));
`ifdef PKT_COMP_SCHED_STATS_EN
    check("stats_mid", 64'(stat_grant_cnt), {16'd3, 16'd4, 16'd3, 16'd3});
`else
    check("stats_mid_off", 64'(stat_grant_cnt), 64'd0);
`endif

    // One pop down to occ 4, then reset while holding
    deq_req       = 1'b1;
    cmp_out_data  = 32'hCAFE_0003;
    cmp_out_prior = 6'd33;
    deq_q.push_back('{data: 32'hCAFE_0003, prior: 6'd33});
    step();
    deq_req = 1'b0;
    check("pre_reset_occ", 64'(occ), 64'd4);
    step();
    rst_n        = 1'b0;
    cmp_in_valid = 1'b1;
    #1;
    check("async_rst_occ", 64'(occ), 64'd0);
    check("async_rst_strobes", 64'({req_ready, cmp_in_en, cmp_out_deque_en}), 64'd0);
    check("async_rst_deq", 64'({deq_valid, deq_data, deq_prior}), 64'd0);
    check("async_rst_hold", {cmp_in_pkt_info, cmp_in_data}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n   = 1'b1;
    deq_req = 1'b1;
    repeat (4) step();
    check("post_rst_occ", 64'(occ), 64'd0);
    check("post_rst_quiet", 64'({cmp_in_en, cmp_out_deque_en, deq_valid}), 64'd0);
    deq_req = 1'b0;

    // Fresh arbitration after reset starts from requester 0
    req_valid = 4'hF;
    gnt_q.push_back(4'b0001);
    ins_q.push_back(mk_ins(0));
    step();
    req_valid = '0;
    repeat (2) step();
    check("final_occ", 64'(occ), 64'd1);
`ifdef PKT_COMP_SCHED_STATS_EN
    check("stats_end", 64'(stat_grant_cnt), {16'd0, 16'd0, 16'd0, 16'd1});
`else
    check("stats_end_off", 64'(stat_grant_cnt), 64'd0);
`endif
    repeat (2) step();
    check("grants_left", 64'(gnt_q.size()), 64'd0);
    check("inserts_left", 64'(ins_q.size()), 64'd0);
    check("deqs_left", 64'(deq_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so the run always terminates
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
